// File: rtl/pipe_control_if.sv
// pipe_control_if: groups the ID-side inputs and staged control outputs of
// pipe_control.
//   i_con_instru / i_con_valid      instruction word in ID and its valid flag
//   i_con_stall_ext / i_con_flush   external stall and branch-taken squash
//   o_con_id_stall                  load-use stall request (combinational)
//   o_con_ex_*, o_con_mem_*, o_con_wb_*  staged control bundle
// The master modport drives the ID side; the slave modport is the controller.
interface pipe_control_if #(
  parameter int AW      = 5,
  parameter int OTHER_W = 4
);
  logic [31:0]        i_con_instru;
  logic               i_con_valid;
  logic               i_con_stall_ext;
  logic               i_con_flush;
  logic               o_con_id_stall;
  logic               o_con_ex_valid;
  logic               o_con_ex_regdst;
  logic               o_con_ex_alusrc;
  logic [1:0]         o_con_ex_aluop;
  logic [OTHER_W-1:0] o_con_ex_other;
  logic               o_con_ex_illegal;
  logic               o_con_mem_valid;
  logic               o_con_mem_read;
  logic               o_con_mem_write;
  logic               o_con_mem_branch;
  logic               o_con_wb_valid;
  logic               o_con_wb_memtoreg;
  logic               o_con_wb_regwrite;
  logic [AW-1:0]      o_con_wb_waddr;

  modport master (
    output i_con_instru, i_con_valid, i_con_stall_ext, i_con_flush,
    input  o_con_id_stall,
    input  o_con_ex_valid, o_con_ex_regdst, o_con_ex_alusrc, o_con_ex_aluop,
    input  o_con_ex_other, o_con_ex_illegal,
    input  o_con_mem_valid, o_con_mem_read, o_con_mem_write, o_con_mem_branch,
    input  o_con_wb_valid, o_con_wb_memtoreg, o_con_wb_regwrite, o_con_wb_waddr
  );

  modport slave (
    input  i_con_instru, i_con_valid, i_con_stall_ext, i_con_flush,
    output o_con_id_stall,
    output o_con_ex_valid, o_con_ex_regdst, o_con_ex_alusrc, o_con_ex_aluop,
    output o_con_ex_other, o_con_ex_illegal,
    output o_con_mem_valid, o_con_mem_read, o_con_mem_write, o_con_mem_branch,
    output o_con_wb_valid, o_con_wb_memtoreg, o_con_wb_regwrite, o_con_wb_waddr
  );
endinterface

// File: rtl/pipe_control.sv
// pipe_control: pipelined MIPS main control. Decodes the ID instruction,
// stages the control bundle through EX/MEM/WB, raises a load-use stall and
// flags undefined opcodes.
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset, clears every stage
//   con      pipe_control_if.slave (ID inputs, stall/flush, staged controls)
module pipe_control #(
  parameter int AW        = 5,
  parameter int OTHER_W   = 4,
  parameter int HAZARD_EN = 1
) (
  input logic          i_clk,
  input logic          i_rst_n,
  pipe_control_if.slave con
);

  typedef struct packed {
    logic               valid;
    logic               regdst;
    logic               alusrc;
    logic [1:0]         aluop;
    logic [OTHER_W-1:0] other;
    logic               illegal;
    logic               memread;
    logic               memwrite;
    logic               branch;
    logic               memtoreg;
    logic               regwrite;
    logic [AW-1:0]      waddr;
  } ex_t;

  typedef struct packed {
    logic          valid;
    logic          memread;
    logic          memwrite;
    logic          branch;
    logic          memtoreg;
    logic          regwrite;
    logic [AW-1:0] waddr;
  } mem_t;

  typedef struct packed {
    logic          valid;
    logic          memtoreg;
    logic          regwrite;
    logic [AW-1:0] waddr;
  } wb_t;

  ex_t  ex_q, dec;
  mem_t mem_q;
  wb_t  wb_q;

  logic [5:0]    op;
  logic [AW-1:0] rs, rt, rd;
  logic [3:0]    other4;
  logic          rt_src;
  logic          id_stall;
  logic          unused_instru;

  assign op = con.i_con_instru[31:26];
  assign rs = AW'(con.i_con_instru[25:21]);
  assign rt = AW'(con.i_con_instru[20:16]);
  assign rd = AW'(con.i_con_instru[15:11]);
  assign unused_instru = ^con.i_con_instru[10:0];

  always_comb begin
    dec    = '0;
    other4 = 4'b0000;
    rt_src = 1'b0;
    casez (op)
      6'b000000: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
        rt_src       = 1'b1;
      end
      6'b001000, 6'b001001, 6'b001100, 6'b001101,
      6'b001110, 6'b001010, 6'b001011, 6'b001111: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = 2'b11;
        case (op)
          6'b001100: other4 = 4'b0001;
          6'b001101: other4 = 4'b0010;
          6'b001110: other4 = 4'b0011;
          6'b001010: other4 = 4'b0110;
          6'b001011: other4 = 4'b0111;
          6'b001111: other4 = 4'b1000;
          default:   other4 = 4'b0000;
        endcase
      end
      6'b100???: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
      end
      6'b101???: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        rt_src       = 1'b1;
      end
      6'b000100, 6'b000101: begin
        dec.branch = 1'b1;
        dec.aluop  = 2'b11;
        other4     = op[0] ? 4'b0101 : 4'b0100;
        rt_src     = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.valid = 1'b1;
    dec.other = OTHER_W'(other4);
    dec.waddr = dec.regdst ? rd : rt;
    // r0 is hardwired; never report a write to it
    if (dec.waddr == '0) dec.regwrite = 1'b0;
  end

  assign id_stall = (HAZARD_EN != 0) && con.i_con_valid && ex_q.valid &&
                    ex_q.memread && (ex_q.waddr != '0) &&
                    ((ex_q.waddr == rs) || (rt_src && (ex_q.waddr == rt)));

  // Flush beats the external stall: the squash must land even while memory
  // is busy, so MEM/WB advance on either flush or no-stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (con.i_con_flush || !con.i_con_stall_ext) begin
      ex_q <= (con.i_con_valid && !con.i_con_flush && !id_stall) ? dec : '0;
      mem_q.valid    <= ex_q.valid;
      mem_q.memread  <= ex_q.memread;
      mem_q.memwrite <= ex_q.memwrite;
      mem_q.branch   <= ex_q.branch;
      mem_q.memtoreg <= ex_q.memtoreg;
      mem_q.regwrite <= ex_q.regwrite;
      mem_q.waddr    <= ex_q.waddr;
      wb_q.valid     <= mem_q.valid;
      wb_q.memtoreg  <= mem_q.memtoreg;
      wb_q.regwrite  <= mem_q.regwrite;
      wb_q.waddr     <= mem_q.waddr;
    end
  end

  assign con.o_con_id_stall    = id_stall;
  assign con.o_con_ex_valid    = ex_q.valid;
  assign con.o_con_ex_regdst   = ex_q.regdst;
  assign con.o_con_ex_alusrc   = ex_q.alusrc;
  assign con.o_con_ex_aluop    = ex_q.aluop;
  assign con.o_con_ex_other    = ex_q.other;
  assign con.o_con_ex_illegal  = ex_q.illegal;
  assign con.o_con_mem_valid   = mem_q.valid;
  assign con.o_con_mem_read    = mem_q.memread;
  assign con.o_con_mem_write   = mem_q.memwrite;
  assign con.o_con_mem_branch  = mem_q.branch;
  assign con.o_con_wb_valid    = wb_q.valid;
  assign con.o_con_wb_memtoreg = wb_q.memtoreg;
  assign con.o_con_wb_regwrite = wb_q.regwrite;
  assign con.o_con_wb_waddr    = wb_q.waddr;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed bench for pipe_control with hand-computed
// expected control bundles for each stage.
module tb_pipe_control;
  logic i_clk;
  logic i_rst_n;
  int   n_checks;
  int   n_errors;

  pipe_control_if #(.AW(5), .OTHER_W(4)) bus ();

  pipe_control #(.AW(5), .OTHER_W(4), .HAZARD_EN(1)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .con     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // {valid, regdst, alusrc, aluop, other, illegal}
  logic [9:0] ex_vec;
  // {valid, read, write, branch}
  logic [3:0] mem_vec;
  // {valid, memtoreg, regwrite, waddr}
  logic [7:0] wb_vec;

  assign ex_vec  = {bus.o_con_ex_valid, bus.o_con_ex_regdst, bus.o_con_ex_alusrc,
                    bus.o_con_ex_aluop, bus.o_con_ex_other, bus.o_con_ex_illegal};
  assign mem_vec = {bus.o_con_mem_valid, bus.o_con_mem_read, bus.o_con_mem_write,
                    bus.o_con_mem_branch};
  assign wb_vec  = {bus.o_con_wb_valid, bus.o_con_wb_memtoreg, bus.o_con_wb_regwrite,
                    bus.o_con_wb_waddr};

  localparam logic [9:0] EX_BUB   = 10'b0;
  localparam logic [9:0] EX_ADDI  = {1'b1, 1'b0, 1'b1, 2'b11, 4'b0000, 1'b0};
  localparam logic [9:0] EX_LW    = {1'b1, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0};
  localparam logic [9:0] EX_RTYPE = {1'b1, 1'b1, 1'b0, 2'b10, 4'b0000, 1'b0};
  localparam logic [9:0] EX_BEQ   = {1'b1, 1'b0, 1'b0, 2'b11, 4'b0100, 1'b0};
  localparam logic [9:0] EX_ORI   = {1'b1, 1'b0, 1'b1, 2'b11, 4'b0010, 1'b0};
  localparam logic [9:0] EX_SLTI  = {1'b1, 1'b0, 1'b1, 2'b11, 4'b0110, 1'b0};
  localparam logic [9:0] EX_SLTIU = {1'b1, 1'b0, 1'b1, 2'b11, 4'b0111, 1'b0};
  localparam logic [9:0] EX_LUI   = {1'b1, 1'b0, 1'b1, 2'b11, 4'b1000, 1'b0};
  localparam logic [9:0] EX_ILL   = {1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1};

  localparam logic [3:0] MEM_ALU  = 4'b1000;
  localparam logic [3:0] MEM_LD   = 4'b1100;
  localparam logic [3:0] MEM_BR   = 4'b1001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr);
    bus.i_con_instru = instr;
    bus.i_con_valid  = 1'b1;
  endtask

  task automatic drain();
    bus.i_con_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex"},    {22'b0, ex_vec}, 32'h0);
    check({tag, "_mem"},   {28'b0, mem_vec}, 32'h0);
    check({tag, "_wb"},    {24'b0, wb_vec}, 32'h0);
    check({tag, "_stall"}, {31'b0, bus.o_con_id_stall}, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    i_rst_n             = 1'b0;
    bus.i_con_instru    = 32'h0;
    bus.i_con_valid     = 1'b0;
    bus.i_con_stall_ext = 1'b0;
    bus.i_con_flush     = 1'b0;
    repeat (2) step();
    check_all_zero("reset");
    i_rst_n = 1'b1;
    step();

    // ADDI rt=5 through all stages
    issue(mk(6'b001000, 5'd1, 5'd5, 5'd0));
    #1 check("addi_stall", {31'b0, bus.o_con_id_stall}, 32'h0);
    step();
    check("addi_ex", {22'b0, ex_vec}, {22'b0, EX_ADDI});
    bus.i_con_valid = 1'b0;
    step();
    check("addi_ex_bub", {22'b0, ex_vec}, {22'b0, EX_BUB});
    check("addi_mem", {28'b0, mem_vec}, {28'b0, MEM_ALU});
    step();
    check("addi_wb", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b0, 1'b1, 5'd5});
    drain();

    // Load-use: LW rt=7 then ADD rs=7
    issue(mk(6'b100011, 5'd2, 5'd7, 5'd0));
    step();
    check("lw_ex", {22'b0, ex_vec}, {22'b0, EX_LW});
    issue(mk(6'b000000, 5'd7, 5'd8, 5'd9));
    #1 check("lu_stall_hi", {31'b0, bus.o_con_id_stall}, 32'h1);
    step();
    check("lu_ex_bub", {22'b0, ex_vec}, {22'b0, EX_BUB});
    check("lu_mem_lw", {28'b0, mem_vec}, {28'b0, MEM_LD});
    check("lu_stall_lo", {31'b0, bus.o_con_id_stall}, 32'h0);
    step();
    check("lu_ex_add", {22'b0, ex_vec}, {22'b0, EX_RTYPE});
    check("lu_wb_lw", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b1, 1'b1, 5'd7});
    bus.i_con_valid = 1'b0;
    step();
    check("lu_mem_add", {28'b0, mem_vec}, {28'b0, MEM_ALU});
    step();
    check("lu_wb_add", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b0, 1'b1, 5'd9});
    drain();

    // Source-use rules with LW rt=7 sitting in EX
    issue(mk(6'b100011, 5'd2, 5'd7, 5'd0));
    step();
    issue(mk(6'b001000, 5'd3, 5'd7, 5'd0));
    #1 check("nf_addi_rt", {31'b0, bus.o_con_id_stall}, 32'h0);
    issue(mk(6'b000000, 5'd1, 5'd7, 5'd4));
    #1 check("rt_rtype", {31'b0, bus.o_con_id_stall}, 32'h1);
    issue(mk(6'b101011, 5'd1, 5'd7, 5'd0));
    #1 check("rt_store", {31'b0, bus.o_con_id_stall}, 32'h1);
    issue(mk(6'b000101, 5'd1, 5'd7, 5'd0));
    #1 check("rt_bne", {31'b0, bus.o_con_id_stall}, 32'h1);
    bus.i_con_valid = 1'b0;
    #1 check("rt_invalid", {31'b0, bus.o_con_id_stall}, 32'h0);
    issue(mk(6'b001000, 5'd3, 5'd7, 5'd0));
    step();
    check("nf_ex_addi", {22'b0, ex_vec}, {22'b0, EX_ADDI});
    issue(mk(6'b000000, 5'd1, 5'd2, 5'd0));
    step();
    check("rd0_ex", {22'b0, ex_vec}, {22'b0, EX_RTYPE});
    bus.i_con_valid = 1'b0;
    step();
    check("nf_wb_addi", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b0, 1'b1, 5'd7});
    step();
    check("rd0_wb", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b0, 1'b0, 5'd0});
    drain();

    // Flush together with external stall, BEQ in MEM
    issue(mk(6'b000100, 5'd1, 5'd2, 5'd0));
    step();
    check("beq_ex", {22'b0, ex_vec}, {22'b0, EX_BEQ});
    issue(mk(6'b001000, 5'd1, 5'd3, 5'd0));
    step();
    check("beq_mem", {28'b0, mem_vec}, {28'b0, MEM_BR});
    issue(mk(6'b001101, 5'd1, 5'd4, 5'd0));
    bus.i_con_flush     = 1'b1;
    bus.i_con_stall_ext = 1'b1;
    step();
    check("fl_ex_bub", {22'b0, ex_vec}, {22'b0, EX_BUB});
    check("fl_mem_addi", {28'b0, mem_vec}, {28'b0, MEM_ALU});
    check("fl_wb_beq", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b0, 1'b0, 5'd2});
    bus.i_con_flush     = 1'b0;
    bus.i_con_stall_ext = 1'b0;
    drain();

    // External stall for 3 cycles with a full pipe
    issue(mk(6'b001101, 5'd1, 5'd4, 5'd0));
    step();
    check("ori_ex", {22'b0, ex_vec}, {22'b0, EX_ORI});
    issue(mk(6'b001110, 5'd1, 5'd5, 5'd0));
    step();
    issue(mk(6'b001010, 5'd1, 5'd6, 5'd0));
    step();
    issue(mk(6'b001011, 5'd1, 5'd10, 5'd0));
    bus.i_con_stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("xs_ex", {22'b0, ex_vec}, {22'b0, EX_SLTI});
      check("xs_mem", {28'b0, mem_vec}, {28'b0, MEM_ALU});
      check("xs_wb", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b0, 1'b1, 5'd4});
    end
    bus.i_con_stall_ext = 1'b0;
    step();
    check("xr_ex_sltiu", {22'b0, ex_vec}, {22'b0, EX_SLTIU});
    check("xr_wb_xori", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b0, 1'b1, 5'd5});
    issue(mk(6'b001111, 5'd0, 5'd11, 5'd0));
    step();
    check("xr_ex_lui", {22'b0, ex_vec}, {22'b0, EX_LUI});
    check("xr_wb_slti", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b0, 1'b1, 5'd6});
    bus.i_con_valid = 1'b0;
    step();
    check("xr_wb_sltiu", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b0, 1'b1, 5'd10});
    step();
    check("xr_wb_lui", {24'b0, wb_vec}, {24'b0, 1'b1, 1'b0, 1'b1, 5'd11});
    drain();

    // Illegal opcode
    issue(mk(6'b111111, 5'd1, 5'd2, 5'd3));
    step();
    check("ill_ex", {22'b0, ex_vec}, {22'b0, EX_ILL});
    bus.i_con_valid = 1'b0;
    step();
    check("ill_clear", {22'b0, ex_vec}, {22'b0, EX_BUB});
    check("ill_mem", {28'b0, mem_vec}, {28'b0, MEM_ALU});

    // Asynchronous reset mid-stream
    issue(mk(6'b100011, 5'd2, 5'd7, 5'd0));
    step();
    issue(mk(6'b000000, 5'd7, 5'd8, 5'd9));
    #2 i_rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    step();
    check_all_zero("rst_hold");
    i_rst_n = 1'b1;
    issue(mk(6'b001000, 5'd1, 5'd5, 5'd0));
    step();
    check("post_rst_ex", {22'b0, ex_vec}, {22'b0, EX_ADDI});
    check("post_rst_mem", {28'b0, mem_vec}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_control.md
# pipe_control

Parametrised, pipelined successor to the MIPS main control decoder. Decodes the full 32-bit instruction in ID, adds SLTI/SLTIU/LUI, and stages the control bundle through EX, MEM and WB registers. Also detects load-use hazards, supports external stall and branch flush, and flags illegal opcodes. Sits between the IF/ID register and the datapath stage registers of the ARC MIPS core.

## Interface
- AW, 5: register address width.
- OTHER_W, 4: width of the ALU sub-operation code `other`; must be at least 4.
- HAZARD_EN, 1: 1 enables load-use stall generation; 0 ties o_con_id_stall low.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- i_con_instru  in  32  instruction word in ID. Fields: op [31:26], rs [25:21], rt [20:16], rd [15:11].
- i_con_valid  in  1  ID slot holds a real instruction.
- i_con_stall_ext  in  1  external stall (memory busy).
- i_con_flush  in  1  branch taken, resolved in MEM; squash the ID instruction.
- o_con_id_stall  out  1  load-use stall request to IF/ID; combinational.
- o_con_ex_valid, o_con_ex_regdst, o_con_ex_alusrc  out  1 each  EX-stage controls.
- o_con_ex_aluop  out  2  EX-stage ALU operation class.
- o_con_ex_other  out  OTHER_W  EX-stage ALU sub-operation.
- o_con_ex_illegal  out  1  instruction in EX has an undefined opcode.
- o_con_mem_valid, o_con_mem_read, o_con_mem_write, o_con_mem_branch  out  1 each  MEM-stage controls.
- o_con_wb_valid, o_con_wb_memtoreg, o_con_wb_regwrite  out  1 each  WB-stage controls.
- o_con_wb_waddr  out  AW  WB destination register.

## Operation
- **Decode** (combinational, on op; fields not listed are 0):
  - 000000 (R-type): regdst=1, regwrite=1, aluop=10.
  - 001000/001001 (ADDI/ADDIU): regwrite, alusrc, aluop=11, other=0000.
  - ANDI 001100 → other=0001; ORI 001101 → 0010; XORI 001110 → 0011; SLTI 001010 → 0110; SLTIU 001011 → 0111; LUI 001111 → 1000. All with regwrite, alusrc, aluop=11.
  - 100??? (loads): regwrite, alusrc, memread, memtoreg, aluop=00.
  - 101??? (stores): alusrc, memwrite, aluop=00. memtoreg=0.
  - BEQ 000100: branch, aluop=11, other=0100. BNE 000101: branch, aluop=11, other=0101.
  - Any other op: all controls 0, illegal=1.
  - `other` is zero-extended to OTHER_W.
- **Write address:** waddr = regdst ? rd : rt. If waddr==0, regwrite is forced to 0.
- **Source use:** rs is always a source. rt is a source for R-type, BEQ, BNE and stores only.
- **Load-use hazard:** stall is asserted when HAZARD_EN, i_con_valid, ex_valid and ex_memread are all set, ex_waddr≠0, and ex_waddr matches rs, or matches rt where rt is a source.
- **Bubble:** valid=0 with every control bit 0. A bubble never drives memread/memwrite/regwrite/branch high.
- **Per-edge update priority** (highest first):
  1. i_con_flush: EX ← bubble; MEM and WB advance, even if i_con_stall_ext is high.
  2. i_con_stall_ext: EX, MEM and WB all hold.
  3. o_con_id_stall: EX ← bubble; MEM and WB advance. Upstream holds ID.
  4. Otherwise: EX ← decode if i_con_valid, else bubble; MEM ← EX; WB ← MEM.
- o_con_id_stall may be high while i_con_stall_ext holds; this has no extra effect.

## Timing
- **Reset:** every output is 0 during reset, including all valids, illegal, waddr and stall.
- **Latency:** an instruction accepted at edge n appears on EX outputs after edge n, on MEM outputs after edge n+1, and on WB outputs after edge n+2.
- o_con_id_stall is combinational from i_con_instru, i_con_valid and the EX register. No register sits on this path.
- A load-use stall lasts exactly one cycle absent an external stall: the load moves to MEM, so the match clears.
- o_con_ex_illegal follows the same registered path as the other EX fields and clears when the instruction leaves EX.
- Reset asserted mid-operation clears all stages immediately (asynchronously). The first accepted instruction after release appears on EX after the first edge.

## Test plan
- **ADDI** op 001000, rt=5, valid, no stalls → next cycle EX: alusrc=1, aluop=11, other=0. Cycle +2: MEM reads/writes 0. Cycle +3: WB regwrite=1, waddr=5.
- **Load-use:** LW rt=7, then ADD rs=7 → o_con_id_stall=1 for one cycle. EX shows a bubble (all 0). The ADD enters EX on the following edge with regdst=1, aluop=10.
- **No false stall:** LW rt=7, then ADDI with rt=7 and rs=3 → no stall, since rt is not a source. R-type with rd=0 → WB regwrite=0.
- **Flush with external stall:** BEQ reaches MEM, then i_con_flush=1 together with i_con_stall_ext=1 → EX becomes a bubble, and MEM/WB advance (flush has priority).
- **External stall:** assert i_con_stall_ext for 3 cycles with a full pipe → all EX/MEM/WB outputs are frozen. On release, the stages resume in order with no loss or duplication.
- **Illegal and reset:** op 111111 → EX illegal=1 with all controls 0. Assert i_rst_n=0 asynchronously mid-stream → all outputs 0 before the next edge.
